hazard_scoreboard: RTL and testbench

- Parametrised load-use hazard unit for the FemtoRV32 pipeline, sitting between IF/ID and ID/EX.
- Replaces single-cycle RD_ID_EX comparison with a per-register countdown scoreboard, so loads with variable memory latency (1..MAX_LAT cycles) stall dependants for exactly the needed cycles.
- Adds flush masking, x0 filtering, a per-source use qualifier and a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard that stalls dependants
// for exactly the remaining latency of an in-flight load, plus a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 3,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_ADDR_W-1:0]        rs1_if_id,
    input  logic [REG_ADDR_W-1:0]        rs2_if_id,
    input  logic                         rs1_use_if_id,
    input  logic                         rs2_use_if_id,
    input  logic                         valid_if_id,
    input  logic                         flush,
    input  logic [REG_ADDR_W-1:0]        rd_id,
    input  logic                         memread_id,
    input  logic [CNT_W-1:0]             load_lat,
    output logic                         pc_stall,
    output logic                         ifid_hold,
    output logic                         bubble_sel,
    output logic [(2**REG_ADDR_W)-1:0]   busy_vec,
    output logic [PERF_W-1:0]            stall_count
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [CNT_W-1:0]  r_cnt [NREGS];
    logic [PERF_W-1:0] r_stall_count;
    logic [CNT_W-1:0]  w_lat;
    logic              w_src1_busy;
    logic              w_src2_busy;
    logic              w_hazard;
    logic              w_issue;

    // Next counter value: saturating decrement, overridden by a larger new latency.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cur,
        input logic             set,
        input logic [CNT_W-1:0] lat
    );
        logic [CNT_W-1:0] dec;
        dec = (cur != {CNT_W{1'b0}}) ? (cur - {{(CNT_W-1){1'b0}}, 1'b1}) : {CNT_W{1'b0}};
        if (set && (lat > dec)) begin
            return lat;
        end else begin
            return dec;
        end
    endfunction

    // Clamp illegal latencies into 1..MAX_LAT.
    always_comb begin
        w_lat = load_lat;
        if (load_lat == {CNT_W{1'b0}}) begin
            w_lat = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (load_lat > CNT_W'(MAX_LAT)) begin
            w_lat = CNT_W'(MAX_LAT);
        end else begin
            w_lat = load_lat;
        end
    end

    // Hazard detection and issue qualification.
    always_comb begin
        w_src1_busy = rs1_use_if_id && (rs1_if_id != {REG_ADDR_W{1'b0}})
                      && (r_cnt[rs1_if_id] != {CNT_W{1'b0}});
        w_src2_busy = rs2_use_if_id && (rs2_if_id != {REG_ADDR_W{1'b0}})
                      && (r_cnt[rs2_if_id] != {CNT_W{1'b0}});
        w_hazard    = valid_if_id && !flush && (w_src1_busy || w_src2_busy);
        w_issue     = valid_if_id && !flush && !w_hazard;
    end

    // Scoreboard counters; x0 is never set so its slot stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= next_cnt(r_cnt[r],
                                     w_issue && memread_id
                                     && (rd_id != {REG_ADDR_W{1'b0}})
                                     && (rd_id == REG_ADDR_W'(r)),
                                     w_lat);
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= {PERF_W{1'b0}};
        end else if (w_hazard && (r_stall_count != {PERF_W{1'b1}})) begin
            r_stall_count <= r_stall_count + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    // Busy vector derived directly from the counters.
    always_comb begin
        busy_vec = {NREGS{1'b0}};
        for (int r = 1; r < NREGS; r++) begin
            busy_vec[r] = (r_cnt[r] != {CNT_W{1'b0}});
        end
    end

    assign pc_stall    = w_hazard;
    assign ifid_hold   = w_hazard;
    assign bubble_sel  = w_hazard;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; PERF_W is reduced so saturation is reachable.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_if_id, rs2_if_id, rd_id;
    logic        rs1_use_if_id, rs2_use_if_id, valid_if_id, flush, memread_id;
    logic [2:0]  load_lat;
    logic        pc_stall, ifid_hold, bubble_sel;
    logic [31:0] busy_vec;
    logic [3:0]  stall_count;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .REG_ADDR_W (5),
        .MAX_LAT    (3),
        .CNT_W      (3),
        .PERF_W     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_if_id     (rs1_if_id),
        .rs2_if_id     (rs2_if_id),
        .rs1_use_if_id (rs1_use_if_id),
        .rs2_use_if_id (rs2_use_if_id),
        .valid_if_id   (valid_if_id),
        .flush         (flush),
        .rd_id         (rd_id),
        .memread_id    (memread_id),
        .load_lat      (load_lat),
        .pc_stall      (pc_stall),
        .ifid_hold     (ifid_hold),
        .bubble_sel    (bubble_sel),
        .busy_vec      (busy_vec),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ifid(input logic v, input logic [4:0] r1, input logic u1,
                            input logic [4:0] r2, input logic u2);
        valid_if_id   = v;
        rs1_if_id     = r1;
        rs1_use_if_id = u1;
        rs2_if_id     = r2;
        rs2_use_if_id = u2;
    endtask

    task automatic set_id(input logic mr, input logic [4:0] rd, input logic [2:0] lat);
        memread_id = mr;
        rd_id      = rd;
        load_lat   = lat;
    endtask

    function automatic logic [63:0] stl();
        return {61'd0, pc_stall, ifid_hold, bubble_sel};
    endfunction

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_ifid(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        step();
        chk("reset_stall", stl(), 64'd0);
        chk("reset_busy", 64'(busy_vec), 64'd0);
        chk("reset_count", 64'(stall_count), 64'd0);
        step();
        rst = 1'b0;

        // No hazard with an empty scoreboard
        step();
        set_ifid(1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        #1;
        chk("nohaz_stall", stl(), 64'd0);
        step();
        chk("nohaz_count", 64'(stall_count), 64'd0);

        // Load x1, L=1: one bubble
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd1, 3'd1);
        step();
        set_ifid(1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("l1_stall", stl(), 64'd7);
        chk("l1_busy", 64'(busy_vec), 64'h2);
        step();
        chk("l1_release", stl(), 64'd0);
        chk("l1_busy_clr", 64'(busy_vec), 64'd0);
        chk("l1_count", 64'(stall_count), 64'd1);
        step();

        // Load x2, L=3: dependant via rs2 stalls three cycles
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd2, 3'd3);
        step();
        set_ifid(1'b1, 5'd0, 1'b0, 5'd2, 1'b1);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("l3_stall_c1", stl(), 64'd7);
        step();
        chk("l3_stall_c2", stl(), 64'd7);
        step();
        chk("l3_stall_c3", stl(), 64'd7);
        step();
        chk("l3_release", stl(), 64'd0);
        chk("l3_count", 64'(stall_count), 64'd4);
        step();

        // Same load, but rs2 not actually read
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd2, 3'd3);
        step();
        set_ifid(1'b1, 5'd0, 1'b0, 5'd2, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("nouse_stall", stl(), 64'd0);
        chk("nouse_busy", 64'(busy_vec), 64'h4);
        step();
        step();
        step();
        chk("nouse_drain", 64'(busy_vec), 64'd0);

        // Illegal latency 0 clamps to 1
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd3, 3'd0);
        step();
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("lat0_busy", 64'(busy_vec), 64'h8);
        step();
        chk("lat0_clr", 64'(busy_vec), 64'd0);

        // Illegal latency 7 clamps to 3
        set_id(1'b1, 5'd3, 3'd7);
        step();
        set_id(1'b0, 5'd0, 3'd0);
        step();
        step();
        chk("lat7_busy2", 64'(busy_vec), 64'h8);
        step();
        chk("lat7_clr3", 64'(busy_vec), 64'd0);

        // Load to x0 and non-load writes never set a counter
        set_id(1'b1, 5'd0, 3'd3);
        step();
        set_ifid(1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        set_id(1'b0, 5'd5, 3'd3);
        #1;
        chk("x0_stall", stl(), 64'd0);
        chk("x0_busy", 64'(busy_vec), 64'd0);
        step();
        chk("nonload_busy", 64'(busy_vec), 64'd0);

        // Load x5, L=3 with a flush on the second stall cycle
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd5, 3'd3);
        step();
        set_ifid(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("fl_stall_c1", stl(), 64'd7);
        step();
        flush = 1'b1;
        #1;
        chk("fl_masked", stl(), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_stall_c3", stl(), 64'd7);
        chk("fl_busy_c3", 64'(busy_vec), 64'h20);
        step();
        chk("fl_release", stl(), 64'd0);
        chk("fl_busy_clr", 64'(busy_vec), 64'd0);
        chk("fl_count", 64'(stall_count), 64'd6);
        step();

        // Back-to-back loads to x4 (L=3 then L=1): max rule keeps 2
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd4, 3'd3);
        step();
        set_id(1'b1, 5'd4, 3'd1);
        step();
        set_ifid(1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("waw_stall_c1", stl(), 64'd7);
        chk("waw_busy", 64'(busy_vec), 64'h10);
        step();
        chk("waw_stall_c2", stl(), 64'd7);
        step();
        chk("waw_release", stl(), 64'd0);
        chk("waw_count", 64'(stall_count), 64'd8);
        step();

        // Nine more stall cycles push the 4-bit counter past its ceiling
        for (int k = 0; k < 3; k++) begin
            set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            set_id(1'b1, 5'd7, 3'd3);
            step();
            set_ifid(1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
            set_id(1'b0, 5'd0, 3'd0);
            step();
            step();
            step();
        end
        chk("sat_count", 64'(stall_count), 64'hF);
        step();

        // Asynchronous reset in the middle of a stall
        set_ifid(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        set_id(1'b1, 5'd6, 3'd3);
        step();
        set_ifid(1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
        set_id(1'b0, 5'd0, 3'd0);
        #1;
        chk("rst_pre_stall", stl(), 64'd7);
        rst = 1'b1;
        #1;
        chk("rst_stall", stl(), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_count", 64'(stall_count), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_after_stall", stl(), 64'd0);
        chk("rst_after_count", 64'(stall_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
